// File: rtl/ripple_add_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master side supplies operands and takes results; the slave side is the adder.
interface ripple_add_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/ripple_add_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple slice, LSB nibble first,
// carrying between nibbles through a register.
module ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module ripple_add_sequencer #(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ripple_add_sequencer_if.slave bus
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("ripple_add_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    logic             in_ready, out_valid;
    logic             accept, last;
    logic [3:0]       a_nib, b_nib, s_sum;
    logic             s_cout, ovf_d;

    assign accept = in_ready && bus.in_valid;
    assign last   = (idx_q == IDX_W'(NIBBLES - 1));

    ripple_adder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Nibble select into the slice and merge of its sum into the working result
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        res_d = res_q;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib            = a_q[4*n +: 4];
                b_nib            = b_q[4*n +: 4];
                res_d[4*n +: 4]  = s_sum;
            end
        end
    end

    assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sum[3] != a_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (bus.in_valid && !rst) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured only on accept; outputs update only on the final pass
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        carry_q <= bus.in_cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= s_cout;
                    if (last) begin
                        idx_q  <= '0;
                        sum_q  <= res_d;
                        cout_q <= s_cout;
                        ovf_q  <= ovf_d;
                    end else begin
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Directed bench for ripple_add_sequencer: a WIDTH=16 instance driven from a vector
// table plus hand sequences, and a WIDTH=4 instance for the single-nibble case.
module tb_ripple_add_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ripple_add_sequencer_if #(.WIDTH(16)) if16 ();
    ripple_add_sequencer_if #(.WIDTH(4))  if4  ();

    ripple_add_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    ripple_add_sequencer #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op16(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        check({nm, " in_ready idle"}, 32'(if16.in_ready), 32'd1);
        if16.in_valid = 1'b1;
        if16.in_a     = a;
        if16.in_b     = b;
        if16.in_cin   = cin;
        tick();
        if16.in_valid = 1'b0;
        check({nm, " in_ready run"}, 32'(if16.in_ready), 32'd0);
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'd4);
        check({nm, " sum"}, 32'(if16.out_sum), 32'(es));
        check({nm, " cout"}, 32'(if16.out_cout), 32'(ec));
        check({nm, " ovf"}, 32'(if16.out_ovf), 32'(eo));
        check({nm, " in_ready done"}, 32'(if16.in_ready), 32'd0);
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
        check({nm, " out_valid drop"}, 32'(if16.out_valid), 32'd0);
    endtask

    task automatic op4(input string nm, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [3:0] es, input logic ec, input logic eo);
        int lat;
        check({nm, " in_ready idle"}, 32'(if4.in_ready), 32'd1);
        if4.in_valid = 1'b1;
        if4.in_a     = a;
        if4.in_b     = b;
        if4.in_cin   = cin;
        tick();
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'd1);
        check({nm, " sum"}, 32'(if4.out_sum), 32'(es));
        check({nm, " cout"}, 32'(if4.out_cout), 32'(ec));
        check({nm, " ovf"}, 32'(if4.out_ovf), 32'(eo));
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        check({nm, " out_valid drop"}, 32'(if4.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0; if16.out_ready = 1'b0;
        if4.in_valid  = 1'b0; if4.in_a  = '0; if4.in_b  = '0; if4.in_cin  = 1'b0; if4.out_ready  = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        check("reset in_ready", 32'(if16.in_ready), 32'd0);
        check("reset out_valid", 32'(if16.out_valid), 32'd0);
        check("reset out_sum", 32'(if16.out_sum), 32'd0);
        check("reset cout/ovf", {30'd0, if16.out_cout, if16.out_ovf}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 32'(if16.in_ready), 32'd1);

        for (int i = 0; i < 8; i++)
            op16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                 vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // Backpressure with in_valid held high through RUN and DONE
        if16.in_valid = 1'b1; if16.in_a = 16'h1234; if16.in_b = 16'h0001; if16.in_cin = 1'b0;
        tick();
        if16.in_a = 16'hAAAA; if16.in_b = 16'h5555; if16.in_cin = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("bp out_valid", 32'(if16.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if16.in_valid = (i % 2 == 0);
            tick();
            check($sformatf("bp hold valid %0d", i), 32'(if16.out_valid), 32'd1);
            check($sformatf("bp hold sum %0d", i), 32'(if16.out_sum), 32'h1235);
            check($sformatf("bp in_ready %0d", i), 32'(if16.in_ready), 32'd0);
        end
        check("bp cout/ovf", {30'd0, if16.out_cout, if16.out_ovf}, 32'd0);
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
        check("bp released", 32'(if16.out_valid), 32'd0);
        op16("bp next", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);

        // out_ready held high while idle/running has no effect
        if16.out_ready = 1'b1;
        tick();
        check("stray out_ready idle", 32'(if16.in_ready), 32'd1);
        if16.out_ready = 1'b0;

        // Reset mid-RUN discards the operation
        if16.in_valid = 1'b1; if16.in_a = 16'h1234; if16.in_b = 16'h1111; if16.in_cin = 1'b0;
        tick();
        if16.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrun rst in_ready", 32'(if16.in_ready), 32'd0);
        check("midrun rst out_sum", 32'(if16.out_sum), 32'd0);
        rst = 1'b0;
        #1;
        check("midrun in_ready after", 32'(if16.in_ready), 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (if16.out_valid) seen++;
            end
            check("midrun no out_valid", 32'(seen), 32'd0);
        end
        op16("after rst", 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0);

        // Reset and in_valid together: nothing accepted
        rst = 1'b1;
        if16.in_valid = 1'b1; if16.in_a = 16'h0101; if16.in_b = 16'h0101;
        tick();
        rst = 1'b0;
        if16.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rst+valid idle", 32'(if16.in_ready), 32'd1);
        check("rst+valid no result", 32'(if16.out_valid), 32'd0);

        op4("w4 a", 4'hC, 4'h7, 1'b1, 4'h4, 1'b1, 1'b0);
        op4("w4 b", 4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0);
        op4("w4 c", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ripple_add_sequencer.md
Name: ripple_add_sequencer

Overview:
- Multi-cycle wide adder built from a single 4-bit ripple_adder slice (ports a, b, cin, sum, cout).
- Accepts WIDTH-bit operands over a valid/ready handshake and feeds the slice one nibble per cycle, LSB nibble first.
- Registers the slice carry between nibbles and assembles the WIDTH-bit result.
- Sits directly upstream of the 4-bit adder and drives all of its inputs; it is also the sole consumer of its outputs.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NIBBLES, WIDTH/4, derived; number of slice passes per operation. Not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand word valid
in_ready  output  1  block can accept an operand word
in_a  input  WIDTH  operand A (unsigned, or two's complement for out_ovf)
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in to nibble 0
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  in_a + in_b + in_cin, modulo 2^WIDTH
out_cout  output  1  carry out of bit WIDTH-1
out_ovf  output  1  signed overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB])

Behaviour:
- Reset (rst high at a clk edge):
  - state <= IDLE; nibble index <= 0; carry register <= 0; operand and result registers <= 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - in_ready is 0 in any cycle where rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_a, in_b; carry <= in_cin; idx <= 0; go to RUN.
  - Without in_valid, remain in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Slice inputs each cycle: a=A[4*idx+:4], b=B[4*idx+:4], cin=carry.
  - At each edge: result[4*idx+:4] <= slice sum; carry <= slice cout; idx <= idx+1.
  - When idx==NIBBLES-1: compute out_cout/out_ovf from this pass, then go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1; out_sum, out_cout, out_ovf are stable and held.
  - in_ready=0; in_valid is ignored.
  - On out_valid&&out_ready: go to IDLE.
- Latency: result visible with out_valid=1 exactly NIBBLES cycles after the accepting edge.
- Throughput: at most one operation per NIBBLES+2 cycles. There is no back-to-back accept from DONE.
- Output stability:
  - out_sum/out_cout/out_ovf change only on the edge entering DONE (or on reset).
  - They hold their last value in IDLE and RUN. Only out_valid qualifies them.
- Arithmetic: the slice is the only adder; no wider adder is inferred. Carry propagates only through the registered carry between nibbles.
- WIDTH=4 (NIBBLES=1): RUN lasts 1 cycle; behaviour is otherwise identical.
- Boundary conditions:
  - in_valid held high in RUN/DONE: not accepted; the operand registers must not change.
  - out_ready high outside DONE: no effect.
  - rst mid-RUN or mid-DONE: operation discarded, no out_valid pulse. in_ready=1 in the first cycle after rst deasserts.
  - rst and in_valid in the same cycle: reset wins; nothing is accepted.
  - idx wraps to 0 on leaving RUN and never indexes beyond NIBBLES-1.

Test Plan:
1. WIDTH=16, a=0x0000, b=0x0000, cin=0 -> out_valid rises 4 cycles after accept; sum=0x0000, cout=0, ovf=0; in_ready low during RUN/DONE.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all 4 nibbles). a=0x00FF, b=0x0001 -> sum=0x0100, cout=0.
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1. a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
4. Backpressure: out_ready low for 5 cycles in DONE while in_valid pulses with new operands -> out_valid stays 1; sum/cout/ovf held; in_ready=0; new operands not latched. After out_ready=1, the next accept produces the new operands' result.
5. Reset: assert rst for 1 cycle after 2 RUN cycles of a=0x1234, b=0x1111 -> no out_valid; outputs=0; in_ready=1 next cycle. A following a=0x1234, b=0x1111, cin=1 -> sum=0x2346.
6. WIDTH=4: a=0xC, b=0x7, cin=1 -> out_valid 1 cycle after accept; sum=0x4, cout=1, ovf=0. a=0x5, b=0xA, cin=0 -> sum=0xF, cout=0.
